// File: rtl/alu_pkg.sv
// ALU op-code encoding shared by the arbiter and its requesters.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SLL  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_AND  = 4'h7,
    ALU_SUB  = 4'h8,
    ALU_LUI  = 4'hB,
    ALU_SRA  = 4'hD
  } alu_op_e;

  function automatic logic is_legal_op(input alu_op_e op);
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_OR, ALU_AND, ALU_SUB, ALU_LUI, ALU_SRA: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// rotating pointer; the pointer moves past the winner when advance is set.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_gnt;
  logic             w_found;

  // base + off stays below 2N, so one conditional subtraction wraps it
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Search starting at the pointer for the first active request
  always_comb begin
    w_gnt     = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[wrap(r_ptr, k)]) begin
        w_found              = 1'b1;
        w_gnt[wrap(r_ptr, k)] = 1'b1;
        w_ptr_nxt            = wrap(r_ptr, k + 1);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Rotating priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters; results land in a
// per-requester response slot one cycle after acceptance.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]   req_op,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       req_b,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [NUM_REQ-1:0][XLEN-1:0]       rsp_data,
  output logic [NUM_REQ-1:0]                 rsp_err,
  output logic [ALU_OP_W-1:0]                alu_op,
  output logic [XLEN-1:0]                    operand_a,
  output logic [XLEN-1:0]                    operand_b,
  input  logic [XLEN-1:0]                    alu_data
);

  logic [NUM_REQ-1:0]           r_rsp_valid;
  logic [NUM_REQ-1:0][XLEN-1:0] r_rsp_data;
  logic [NUM_REQ-1:0]           r_rsp_err;

  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ALU_OP_W-1:0] w_sel_op;
  logic [XLEN-1:0]     w_sel_a;
  logic [XLEN-1:0]     w_sel_b;
  logic                w_sel_legal;

  // A slot freed by rsp_ready this cycle can take a new result at the same edge
  assign w_eligible = req_valid & (~r_rsp_valid | rsp_ready);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_eligible),
    .i_advance (1'b1),
    .o_gnt     (w_gnt)
  );

  // Select the granted request; with no grant this defaults to ADD 0,0
  always_comb begin
    w_sel_op = ALU_ADD;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_op = req_op[i];
        w_sel_a  = req_a[i];
        w_sel_b  = req_b[i];
      end else begin
        w_sel_op = w_sel_op;
      end
    end
    w_sel_legal = is_legal_op(alu_op_e'(w_sel_op));
  end

  // Illegal ops never reach the ALU; it sees the idle ADD 0,0 instead
  always_comb begin
    if (w_sel_legal) begin
      alu_op    = w_sel_op;
      operand_a = w_sel_a;
      operand_b = w_sel_b;
    end else begin
      alu_op    = ALU_ADD;
      operand_a = '0;
      operand_b = '0;
    end
  end

  // Response slots: fill on grant, drain on rsp_ready, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= w_sel_legal ? alu_data : '0;
          r_rsp_err[i]   <= ~w_sel_legal;
        end else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end else begin
          r_rsp_valid[i] <= r_rsp_valid[i];
        end
      end
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a queue-free behavioural model of grant order and slots.
module tb_alu_arbiter;

  localparam int NR = 2;
  localparam int XL = 32;

  logic                  clk;
  logic                  rst_n;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0][3:0]    req_op;
  logic [NR-1:0][XL-1:0] req_a;
  logic [NR-1:0][XL-1:0] req_b;
  logic [NR-1:0]         rsp_valid;
  logic [NR-1:0]         rsp_ready;
  logic [NR-1:0][XL-1:0] rsp_data;
  logic [NR-1:0]         rsp_err;
  logic [3:0]            alu_op;
  logic [XL-1:0]         operand_a;
  logic [XL-1:0]         operand_b;
  logic [XL-1:0]         alu_data;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .alu_data(alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'h0: alu_ref = a + b;
      4'h1: alu_ref = a << b[4:0];
      4'h2: alu_ref = {31'd0, ($signed(a) < $signed(b))};
      4'h3: alu_ref = {31'd0, (a < b)};
      4'h4: alu_ref = a ^ b;
      4'h5: alu_ref = a >> b[4:0];
      4'h6: alu_ref = a | b;
      4'h7: alu_ref = a & b;
      4'h8: alu_ref = a - b;
      4'hB: alu_ref = b;
      4'hD: alu_ref = sa >>> b[4:0];
      default: alu_ref = 32'd0;
    endcase
  endfunction

  function automatic bit legal_ref(input logic [3:0] op);
    return (op <= 4'h8) || (op == 4'hB) || (op == 4'hD);
  endfunction

  // Environment ALU
  assign alu_data = alu_ref(alu_op, operand_a, operand_b);

  // Behavioural model: pointer, per-port slot occupancy and contents
  int          m_ptr;
  logic [1:0]  m_valid;
  logic [31:0] m_data [2];
  logic [1:0]  m_err;
  int          exp_g;

  function automatic int model_grant();
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (req_valid[i] && (!m_valid[i] || rsp_ready[i])) return i;
    end
    return -1;
  endfunction

  assign exp_g = model_grant();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0;
      m_valid <= 2'b00;
      m_err <= 2'b00;
      m_data[0] <= 32'd0;
      m_data[1] <= 32'd0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (i == exp_g) begin
          m_valid[i] <= 1'b1;
          m_data[i]  <= legal_ref(req_op[i]) ? alu_ref(req_op[i], req_a[i], req_b[i]) : 32'd0;
          m_err[i]   <= !legal_ref(req_op[i]);
        end else if (rsp_ready[i]) begin
          m_valid[i] <= 1'b0;
        end
      end
      if (exp_g >= 0) m_ptr <= (exp_g + 1) % NR;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin
      errors++; $display("FAIL reset_flags: valid=%b err=%b required 00/00", rsp_valid, rsp_err);
    end
    checks++;
    if (rsp_data !== '0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_data: data=%h ready=%b required 0/00", rsp_data, req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    req_valid = 2'b01; req_op[0] = 4'h0; req_a[0] = 32'd5; req_b[0] = 32'd7; rsp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01 || alu_op !== 4'h0 || operand_a !== 32'd5 || operand_b !== 32'd7) begin
      errors++; $display("FAIL add_accept: ready=%b op=%h a=%h b=%h required 01/0/5/7", req_ready, alu_op, operand_a, operand_b);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd12 || rsp_err[0] !== 1'b0) begin
      errors++; $display("FAIL add_rsp: valid=%b data=%h err=%b required 1/c/0", rsp_valid[0], rsp_data[0], rsp_err[0]);
    end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_op[0] = 4'h8; req_a[0] = 32'd10; req_b[0] = 32'd3;
    req_op[1] = 4'h2; req_a[1] = 32'hffff_ffff; req_b[1] = 32'd1;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % 2;
      #1;
      checks++;
      if (req_ready !== (2'b01 << g)) begin
        errors++; $display("FAIL alt_grant%0d: ready=%b required %b", k, req_ready, 2'b01 << g);
      end
      tick();
      checks++;
      if (rsp_valid[g] !== 1'b1 || rsp_data[g] !== ((g == 0) ? 32'd7 : 32'd1)) begin
        errors++; $display("FAIL alt_rsp%0d: valid=%b data=%h required 1/%h", k, rsp_valid[g], rsp_data[g], (g == 0) ? 32'd7 : 32'd1);
      end
    end
    idle_inputs(); rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b10;
    req_op[0] = 4'h7; req_a[0] = 32'h0000_f0f0; req_b[0] = 32'h0000_0ff0;
    req_op[1] = 4'h0; req_a[1] = 32'd1; req_b[1] = 32'd2;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL stall_first: ready=%b required 01", req_ready);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready !== 2'b10) begin
        errors++; $display("FAIL stall_grant%0d: ready=%b required 10", k, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 2'b11 || rsp_data[0] !== 32'h0000_00f0 || rsp_data[1] !== 32'd3) begin
        errors++; $display("FAIL stall_hold%0d: valid=%b d0=%h d1=%h required 11/f0/3", k, rsp_valid, rsp_data[0], rsp_data[1]);
      end
    end
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL stall_release: ready=%b required 01", req_ready);
    end
    idle_inputs(); rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_illegal_op();
    do_reset();
    req_valid = 2'b10; rsp_ready = 2'b11;
    req_op[1] = 4'hE; req_a[1] = 32'd123; req_b[1] = 32'd456;
    #1;
    checks++;
    if (req_ready !== 2'b10 || alu_op !== 4'h0 || operand_a !== 32'd0 || operand_b !== 32'd0) begin
      errors++; $display("FAIL illegal_drive: ready=%b op=%h a=%h b=%h required 10/0/0/0", req_ready, alu_op, operand_a, operand_b);
    end
    tick();
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_err[1] !== 1'b1 || rsp_data[1] !== 32'd0) begin
      errors++; $display("FAIL illegal_rsp: valid=%b err=%b data=%h required 1/1/0", rsp_valid[1], rsp_err[1], rsp_data[1]);
    end
    req_op[1] = 4'hD; req_a[1] = 32'h8000_0000; req_b[1] = 32'd4;
    tick();
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_err[1] !== 1'b0 || rsp_data[1] !== 32'hf800_0000) begin
      errors++; $display("FAIL sra_rsp: valid=%b err=%b data=%h required 1/0/f8000000", rsp_valid[1], rsp_err[1], rsp_data[1]);
    end
    idle_inputs(); rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b11;
    req_op[0] = 4'h0; req_a[0] = 32'd1; req_b[0] = 32'd1;
    tick();
    req_op[0] = 4'h4; req_a[0] = 32'h0000_a5a5; req_b[0] = 32'h0000_ffff;
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd2 || req_ready !== 2'b01) begin
      errors++; $display("FAIL b2b_first: valid=%b data=%h ready=%b required 1/2/01", rsp_valid[0], rsp_data[0], req_ready);
    end
    tick();
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h0000_5a5a) begin
      errors++; $display("FAIL b2b_second: valid=%b data=%h required 1/5a5a", rsp_valid[0], rsp_data[0]);
    end
    idle_inputs(); rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b00;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 2'b11) begin
      errors++; $display("FAIL arst_fill: valid=%b required 11", rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++; $display("FAIL arst_clear: valid=%b required 00", rsp_valid);
    end
    tick();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL arst_first_grant: ready=%b required 01", req_ready);
    end
    idle_inputs(); rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int i = 0; i < NR; i++) begin
        req_op[i] = 4'($urandom_range(0, 15));
        req_a[i]  = $urandom;
        req_b[i]  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      end
      #1;
      checks++;
      if (req_ready !== ((exp_g >= 0) ? (2'b01 << exp_g) : 2'b00)) begin
        errors++; $display("FAIL rnd_ready@%0d: ready=%b model_grant=%0d", n, req_ready, exp_g);
      end
      if (exp_g >= 0 && legal_ref(req_op[exp_g])) begin
        checks++;
        if (alu_op !== req_op[exp_g] || operand_a !== req_a[exp_g] || operand_b !== req_b[exp_g]) begin
          errors++; $display("FAIL rnd_alu_drive@%0d: op=%h a=%h b=%h required %h/%h/%h", n, alu_op, operand_a, operand_b, req_op[exp_g], req_a[exp_g], req_b[exp_g]);
        end
      end
      tick();
      checks++;
      if (rsp_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid@%0d: valid=%b required %b", n, rsp_valid, m_valid);
      end
      for (int i = 0; i < NR; i++) begin
        if (m_valid[i]) begin
          checks++;
          if (rsp_data[i] !== m_data[i] || rsp_err[i] !== m_err[i]) begin
            errors++; $display("FAIL rnd_rsp%0d@%0d: data=%h err=%b required %h/%b", i, n, rsp_data[i], rsp_err[i], m_data[i], m_err[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_alternate();
    test_stall();
    test_illegal_op();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
